// File: rtl/explored_set_pkg.sv
// explored_set_pkg: node record layout, op/state encodings and key-field positions
package explored_set_pkg;
  typedef struct packed {
    logic [31:0]  f_cost;
    logic [15:0]  node_id;
    logic [15:0]  parent_node_id;
    logic [15:0]  current_cost;
    logic [15:0]  heuristic;
    logic [175:0] payload;
  } node_info_t;
  typedef enum logic [1:0] {OP_FIND, OP_INSERT, OP_CLEAR, OP_RSVD} op_e;
  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_WRITE, S_DONE} state_e;
  localparam int NODE_ID_LSB   = 224;
  localparam int PARENT_ID_LSB = 208;
  localparam int NODE_INFO_W   = $bits(node_info_t);
endpackage

// File: rtl/explored_set_if.sv
// explored_set_if: request/response bundle between a requester (master) and the explored set (slave)
interface explored_set_if #(
  parameter int DATA_W = 272,
  parameter int KEY_W  = 16,
  parameter int AW     = 8
);
  logic              start;
  logic [1:0]        op;
  logic [KEY_W-1:0]  key;
  logic [DATA_W-1:0] wr_record;
  logic              busy;
  logic              done;
  logic              hit;
  logic [AW-1:0]     hit_addr;
  logic [DATA_W-1:0] rd_record;
  logic [AW:0]       count;
  logic              full;
  logic              error;
  modport master (
    output start, op, key, wr_record,
    input  busy, done, hit, hit_addr, rd_record, count, full, error
  );
  modport slave (
    input  start, op, key, wr_record,
    output busy, done, hit, hit_addr, rd_record, count, full, error
  );
endinterface

// File: rtl/explored_set_ram.sv
// explored_set_ram: simple dual-port record memory, one write port and a registered read port
module explored_set_ram #(
  parameter int DEPTH = 255,
  parameter int W     = 272,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
`ifdef ALTERA_RESERVED_QIS
  altsyncram #(
    .operation_mode("DUAL_PORT"),
    .width_a(W), .widthad_a(AW), .numwords_a(DEPTH),
    .width_b(W), .widthad_b(AW), .numwords_b(DEPTH),
    .address_reg_b("CLOCK0"), .outdata_reg_b("UNREGISTERED"),
    .ram_block_type("M10K"),
    .read_during_write_mode_mixed_ports("DONT_CARE")
  ) u_ram (
    .clock0(clk), .wren_a(we), .address_a(waddr), .data_a(wdata),
    .rden_b(re), .address_b(raddr), .q_b(rdata)
  );
`else
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
`endif
endmodule

// File: rtl/explored_set.sv
// explored_set: pipelined linear-search explored set with FIND, INSERT (upsert) and CLEAR
module explored_set
  import explored_set_pkg::*;
#(
  parameter int MAX_NODES = 255,
  parameter int DATA_W    = NODE_INFO_W,
  parameter int KEY_W     = 16,
  parameter int KEY_LSB   = NODE_ID_LSB
) (
  input logic clk,
  input logic reset,
  explored_set_if.slave bus
);
  localparam int AW = $clog2(MAX_NODES);
  localparam logic [AW:0] CAP = (AW+1)'(MAX_NODES);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [KEY_W-1:0] key_q, key_d, key_in;
  logic [DATA_W-1:0] rec_q, rec_d, rd_q, rd_d, rdata;
  logic [AW:0] addr_q, addr_d, count_q, count_d;
  logic [AW-1:0] ra_q, ra_d, hit_addr_q, hit_addr_d;
  logic iss_q, iss_d, rv_q, rv_d, hit_q, hit_d, err_q, err_d, done_q, done_d, busy_q, full_q;
  logic match, last;
  assign key_in = bus.op == OP_INSERT ? bus.wr_record[KEY_LSB +: KEY_W] : bus.key;
  assign match = rv_q && rdata[KEY_LSB +: KEY_W] == key_q;
  assign last = rv_q && {1'b0, ra_q} + (AW+1)'(1) == count_q;
  explored_set_ram #(.DEPTH(MAX_NODES), .W(DATA_W), .AW(AW)) u_ram (
    .clk(clk),
    .we(state_q == S_WRITE && !reset),
    .waddr(hit_addr_q),
    .wdata(rec_q),
    .re(iss_q),
    .raddr(addr_q[AW-1:0]),
    .rdata(rdata)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    key_d = key_q;
    rec_d = rec_q;
    addr_d = addr_q;
    iss_d = 1'b0;
    rv_d = 1'b0;
    ra_d = ra_q;
    hit_d = hit_q;
    hit_addr_d = hit_addr_q;
    rd_d = rd_q;
    count_d = count_q;
    err_d = err_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        op_d = op_e'(bus.op);
        key_d = key_in;
        rec_d = bus.wr_record;
        addr_d = '0;
        hit_d = 1'b0;
        err_d = 1'b0;
        rd_d = '0;
        if (bus.op == OP_RSVD || (bus.op != OP_CLEAR && key_in == '0)) begin
          err_d = 1'b1;
          state_d = S_DONE;
          done_d = 1'b1;
        end else if (bus.op == OP_CLEAR) begin
          count_d = '0;
          state_d = S_DONE;
          done_d = 1'b1;
        end else begin
          iss_d = count_q != '0;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        rv_d = iss_q;
        ra_d = addr_q[AW-1:0];
        if (iss_q) begin
          addr_d = addr_q + (AW+1)'(1);
          iss_d = addr_q + (AW+1)'(1) < count_q;
        end
        if (match || last || count_q == '0) begin
          iss_d = 1'b0;
          rv_d = 1'b0;
          if (match) begin
            hit_d = 1'b1;
            hit_addr_d = ra_q;
            rd_d = op_q == OP_FIND ? rdata : '0;
          end
          if (op_q == OP_FIND) begin
            state_d = S_DONE;
            done_d = 1'b1;
          end else if (match) begin
            state_d = S_WRITE;
          end else if (count_q == CAP) begin
            err_d = 1'b1;
            state_d = S_DONE;
            done_d = 1'b1;
          end else begin
            hit_addr_d = count_q[AW-1:0];
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        count_d = hit_q ? count_q : count_q + (AW+1)'(1);
        state_d = S_DONE;
        done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q <= OP_FIND;
      key_q <= '0;
      rec_q <= '0;
      addr_q <= '0;
      iss_q <= 1'b0;
      rv_q <= 1'b0;
      ra_q <= '0;
      hit_q <= 1'b0;
      hit_addr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      key_q <= key_d;
      rec_q <= rec_d;
      addr_q <= addr_d;
      iss_q <= iss_d;
      rv_q <= rv_d;
      ra_q <= ra_d;
      hit_q <= hit_d;
      hit_addr_q <= hit_addr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      full_q <= count_d == CAP;
      err_q <= err_d;
      done_q <= done_d;
      busy_q <= state_d != S_IDLE;
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hit = hit_q;
  assign bus.hit_addr = hit_addr_q;
  assign bus.rd_record = rd_q;
  assign bus.count = count_q;
  assign bus.full = full_q;
  assign bus.error = err_q;
endmodule
